// File: rtl/wash_program.sv
// wash_program: wash-cycle program selector and phase sequencer.
//   cp, rst      : clock (rising edge), synchronous active-high reset
//   state        : system state (0 shutDown, 1 begin, 2 set, 3 run,
//                  4 error, 5 pause, 6 finish)
//   click        : selection pulse; with timeBtn=1 it adjusts a custom time
//   timeBtn      : qualifies click as a time adjust
//   adjSel       : phase whose custom time is adjusted
//   tick         : one-cycle time-unit pulse
//   mode         : selected program (all ones = custom)
//   phaseMask    : enabled phases
//   phaseTime    : packed per-phase times, phase i at [i*TW +: TW]
//   curPhase     : phase being executed
//   remain       : time left in curPhase
//   totalRemain  : time left in the whole program
//   phaseDone    : one-cycle pulse at the end of each phase
//   allDone      : sticky program-complete flag
module wash_program #(
  parameter int N_PHASE  = 3,
  parameter int TW       = 3,
  parameter int DEF_TIME = 3,
  parameter int MAX_TIME = 7,
  localparam int AW  = (N_PHASE > 1) ? $clog2(N_PHASE) : 1,
  localparam int TRW = TW + AW + 1
) (
  input  logic                  cp,
  input  logic                  rst,
  input  logic [2:0]            state,
  input  logic                  click,
  input  logic                  timeBtn,
  input  logic [AW-1:0]         adjSel,
  input  logic                  tick,
  output logic [N_PHASE-1:0]    mode,
  output logic [N_PHASE-1:0]    phaseMask,
  output logic [N_PHASE*TW-1:0] phaseTime,
  output logic [AW-1:0]         curPhase,
  output logic [TW-1:0]         remain,
  output logic [TRW-1:0]        totalRemain,
  output logic                  phaseDone,
  output logic                  allDone
);

  typedef enum logic [2:0] {
    ST_SHUTDOWN = 3'd0,
    ST_BEGIN    = 3'd1,
    ST_SET      = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FINISH   = 3'd6
  } sys_state_e;

  sys_state_e    st, prev_st;
  logic [TW-1:0] ctime [N_PHASE];
  logic [TW-1:0] ptime [N_PHASE];
  logic          custom;
  logic [AW-1:0] first_ph, next_ph;
  logic          first_ok, next_ok;
  logic          run_entry;

  assign st        = sys_state_e'(state);
  // Resuming from pause is not an entry, so the loaded phase survives.
  assign run_entry = (st == ST_RUN) && (prev_st != ST_RUN) && (prev_st != ST_PAUSE);

  // Presets: mask = all-ones minus mode, which is simply ~mode.
  always_comb begin
    custom    = &mode;
    phaseMask = custom ? '1 : ~mode;
    phaseTime = '0;
    for (int unsigned i = 0; i < N_PHASE; i++) begin
      ptime[i] = '0;
      if (phaseMask[i])
        ptime[i] = custom ? ctime[i] : TW'(DEF_TIME);
      phaseTime[i*TW +: TW] = ptime[i];
    end
  end

  // Lowest enabled phase, next enabled phase above curPhase, and the
  // time still owed by everything after the current phase.
  always_comb begin
    first_ph    = '0;
    first_ok    = 1'b0;
    next_ph     = '0;
    next_ok     = 1'b0;
    totalRemain = TRW'(remain);
    for (int unsigned i = 0; i < N_PHASE; i++) begin
      if (phaseMask[i] && !first_ok) begin
        first_ph = AW'(i);
        first_ok = 1'b1;
      end
      if (phaseMask[i] && (i > 32'(curPhase))) begin
        if (!next_ok) begin
          next_ph = AW'(i);
          next_ok = 1'b1;
        end
        totalRemain = totalRemain + TRW'(ptime[i]);
      end
    end
    if (allDone)
      totalRemain = '0;
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      mode      <= '0;
      curPhase  <= '0;
      remain    <= '0;
      phaseDone <= 1'b0;
      allDone   <= 1'b0;
      prev_st   <= ST_SHUTDOWN;
      for (int unsigned i = 0; i < N_PHASE; i++)
        ctime[i] <= TW'(DEF_TIME);
    end else begin
      prev_st   <= st;
      phaseDone <= 1'b0;
      case (st)
        ST_SHUTDOWN: begin
          curPhase <= '0;
          remain   <= '0;
          allDone  <= 1'b0;
        end
        ST_BEGIN: begin
          mode     <= '0;
          curPhase <= '0;
          remain   <= '0;
          allDone  <= 1'b0;
          for (int unsigned i = 0; i < N_PHASE; i++)
            ctime[i] <= TW'(DEF_TIME);
        end
        ST_SET: begin
          if (click) begin
            if (timeBtn) begin
              mode <= '1;
              for (int unsigned i = 0; i < N_PHASE; i++)
                if ((32'(adjSel) == i) && (ctime[i] < TW'(MAX_TIME)))
                  ctime[i] <= ctime[i] + TW'(1);
            end else begin
              mode <= mode + 1'b1;
              for (int unsigned i = 0; i < N_PHASE; i++)
                ctime[i] <= TW'(DEF_TIME);
            end
          end
        end
        ST_RUN: begin
          if (run_entry) begin
            curPhase <= first_ph;
            remain   <= ptime[first_ph];
            allDone  <= 1'b0;
          end else if (tick && !allDone) begin
            if (remain > TW'(1)) begin
              remain <= remain - TW'(1);
            end else if (remain == TW'(1)) begin
              phaseDone <= 1'b1;
              if (next_ok) begin
                curPhase <= next_ph;
                remain   <= ptime[next_ph];
              end else begin
                remain  <= '0;
                allDone <= 1'b1;
              end
            end
          end
        end
        default: ;  // error, pause, finish: hold
      endcase
    end
  end

endmodule

// File: tb/tb_wash_program.sv
module tb_wash_program;

  logic       cp = 1'b0;
  logic       rst, click, timeBtn, tick;
  logic [2:0] state;
  logic [1:0] adjSel;
  logic [2:0] mode, phaseMask, curPhase, remain;
  logic [8:0] phaseTime;
  logic [1:0] curPhase_w;
  logic [5:0] totalRemain;
  logic       phaseDone, allDone;

  assign curPhase = {1'b0, curPhase_w};

  wash_program #(.N_PHASE(3), .TW(3), .DEF_TIME(3), .MAX_TIME(7)) dut (
    .cp(cp), .rst(rst), .state(state), .click(click), .timeBtn(timeBtn),
    .adjSel(adjSel), .tick(tick), .mode(mode), .phaseMask(phaseMask),
    .phaseTime(phaseTime), .curPhase(curPhase_w), .remain(remain),
    .totalRemain(totalRemain), .phaseDone(phaseDone), .allDone(allDone)
  );

  always #5 cp = ~cp;

  typedef enum {S_MODE, S_MASK, S_PTIME, S_CUR, S_REM, S_TOT, S_PD, S_AD} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] obs(sig_e s);
    case (s)
      S_MODE:  return 32'(mode);
      S_MASK:  return 32'(phaseMask);
      S_PTIME: return 32'(phaseTime);
      S_CUR:   return 32'(curPhase);
      S_REM:   return 32'(remain);
      S_TOT:   return 32'(totalRemain);
      S_PD:    return 32'(phaseDone);
      default: return 32'(allDone);
    endcase
  endfunction

  task automatic expect_v(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = 32'(v);
    sb.push_back(e);
  endtask

  // Advance one clock edge, then compare every pending expectation.
  task automatic cyc();
    exp_t e;
    logic [31:0] o;
    @(posedge cp);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic expect_regs(input string tag, input int c, input int r,
                             input int pd, input int ad);
    expect_v({tag, ".cur"}, S_CUR, c);
    expect_v({tag, ".rem"}, S_REM, r);
    expect_v({tag, ".pd"},  S_PD,  pd);
    expect_v({tag, ".ad"},  S_AD,  ad);
  endtask

  initial begin
    rst = 1'b1; state = 3'd0; click = 1'b0; timeBtn = 1'b0; adjSel = 2'd0; tick = 1'b0;
    cyc();
    expect_v("rst.mode", S_MODE, 0);
    expect_regs("rst", 0, 0, 0, 0);
    expect_v("rst.tot", S_TOT, 6);
    cyc();
    rst = 1'b0;

    // Mode stepping through all programs, wrapping back to 0.
    state = 3'd2; click = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      expect_v($sformatf("step.mode%0d", k), S_MODE, k % 8);
      if (k == 1) begin
        expect_v("mode1.mask", S_MASK, 6);
        expect_v("mode1.ptime", S_PTIME, (3 << 6) | (3 << 3));
      end
      if (k == 8) expect_v("mode0.mask", S_MASK, 7);
      cyc();
    end

    // Custom time adjust on phase 1, saturating at 7.
    timeBtn = 1'b1; adjSel = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      expect_v("adj.mode", S_MODE, 7);
      expect_v($sformatf("adj.ptime%0d", k), S_PTIME,
               (3 << 6) | (((k + 3 > 7) ? 7 : k + 3) << 3) | 3);
      cyc();
    end
    adjSel = 2'd3;
    expect_v("adjbad.ptime", S_PTIME, (3 << 6) | (7 << 3) | 3);
    expect_v("adjbad.mode", S_MODE, 7);
    cyc();

    // Run entry on custom program, then a click that must be ignored.
    click = 1'b0; timeBtn = 1'b0; state = 3'd3;
    expect_regs("cust.entry", 0, 3, 0, 0);
    expect_v("cust.tot", S_TOT, 13);
    cyc();
    click = 1'b1;
    expect_v("runclick.mode", S_MODE, 7);
    expect_v("runclick.rem", S_REM, 3);
    cyc();
    click = 1'b0; tick = 1'b1;
    expect_v("cust.tick.rem", S_REM, 2);
    expect_v("cust.tick.tot", S_TOT, 12);
    cyc();

    // Back to begin: defaults reload, then full mode-0 run.
    tick = 1'b0; state = 3'd1;
    expect_v("begin.mode", S_MODE, 0);
    expect_regs("begin", 0, 0, 0, 0);
    cyc();
    state = 3'd2;
    cyc();
    state = 3'd3; tick = 1'b1;  // tick on the entry cycle is ignored
    expect_regs("m0.entry", 0, 3, 0, 0);
    expect_v("m0.entry.tot", S_TOT, 9);
    cyc();
    for (int k = 1; k <= 9; k++) begin
      expect_regs($sformatf("m0.t%0d", k), (k == 9) ? 2 : k / 3,
                  (k == 9) ? 0 : 3 - (k % 3), (k % 3 == 0) ? 1 : 0, (k == 9) ? 1 : 0);
      expect_v($sformatf("m0.t%0d.tot", k), S_TOT, 9 - k);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      expect_regs("m0.after", 2, 0, 0, 1);
      expect_v("m0.after.tot", S_TOT, 0);
      cyc();
    end
    tick = 1'b0; state = 3'd6;
    expect_v("finish.ad", S_AD, 1);
    cyc();

    // Mode 5 (mask 010): entry lands on phase 1; pause/resume.
    state = 3'd1;
    cyc();
    state = 3'd2; click = 1'b1;
    repeat (4) cyc();
    expect_v("m5.mode", S_MODE, 5);
    expect_v("m5.mask", S_MASK, 2);
    expect_v("m5.ptime", S_PTIME, 3 << 3);
    cyc();
    click = 1'b0; state = 3'd3;
    expect_regs("m5.entry", 1, 3, 0, 0);
    expect_v("m5.entry.tot", S_TOT, 3);
    cyc();
    tick = 1'b1;
    expect_v("m5.t1.rem", S_REM, 2);
    cyc();
    expect_v("m5.t2.rem", S_REM, 1);
    expect_v("m5.t2.tot", S_TOT, 1);
    cyc();
    state = 3'd5;
    for (int k = 0; k < 4; k++) begin
      expect_regs("pause", 1, 1, 0, 0);
      cyc();
    end
    state = 3'd3; tick = 1'b0;
    expect_regs("resume", 1, 1, 0, 0);
    cyc();
    tick = 1'b1;
    expect_regs("m5.done", 1, 0, 1, 1);
    expect_v("m5.done.tot", S_TOT, 0);
    cyc();
    tick = 1'b0; state = 3'd0;
    expect_v("shutdown.mode", S_MODE, 5);
    expect_regs("shutdown", 0, 0, 0, 0);
    cyc();

    // Reset mid-run.
    state = 3'd1;
    cyc();
    state = 3'd2;
    cyc();
    state = 3'd3;
    cyc();
    tick = 1'b1;
    cyc();
    expect_regs("mid.pre", 0, 1, 0, 0);
    cyc();
    rst = 1'b1;
    expect_v("midrst.mode", S_MODE, 0);
    expect_regs("midrst", 0, 0, 0, 0);
    cyc();
    rst = 1'b0;  // prev state cleared, so staying in run is a fresh entry
    expect_regs("post.entry", 0, 3, 0, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
